// File: rtl/program_counter.sv
// Program counter with LIFO return-address stack for CALL/RET; 1-cycle update latency.
// No backpressure: strobes act on the edge they are sampled, overflow/underflow are flagged sticky.
module program_counter #(
  parameter int          ADDR_W    = 8,
  parameter int          DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = 8'h00
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              increment,
  input  logic              execute,
  input  logic              en_pc,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0] stack_mem [DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  sp_nxt;
  logic [PTR_W-1:0]  sp_dec;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic              ovf_nxt;
  logic              unf_nxt;
  logic              push;

  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == PTR_W'(DEPTH));
  assign sp_dec      = sp - PTR_W'(1);
  assign top_idx     = sp_dec[IDX_W-1:0];
  assign push_idx    = sp[IDX_W-1:0];
  assign pc_inc      = pc + ADDR_W'(1);

  // ret outranks call, and execute outranks increment
  always_comb begin
    pc_nxt  = pc;
    sp_nxt  = sp;
    ovf_nxt = stack_ovf;
    unf_nxt = stack_unf;
    push    = 1'b0;
    if (en_pc) begin
      if (execute) begin
        if (ret) begin
          if (!stack_empty) begin
            pc_nxt = stack_mem[top_idx];
            sp_nxt = sp_dec;
          end else begin
            pc_nxt  = RESET_VEC;
            unf_nxt = 1'b1;
          end
        end else if (call) begin
          pc_nxt = jump_addr;
          if (!stack_full) begin
            push   = 1'b1;
            sp_nxt = sp + PTR_W'(1);
          end else begin
            ovf_nxt = 1'b1;
          end
        end else begin
          pc_nxt = jump_addr;
        end
      end else if (increment) begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      pc        <= RESET_VEC;
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      sp        <= sp_nxt;
      stack_ovf <= ovf_nxt;
      stack_unf <= unf_nxt;
    end
  end

  // Return address is pc+1: during execute pc still points at the CALL itself
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule
